// File: rtl/alu_sequencer_if.sv
// Request/response and alu-side signal bundle for alu_sequencer.
// master = sequencer, slave = CPU control plus the alu instance.
interface alu_sequencer_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned OP_W   = 4
);
   logic              req_valid;
   logic              req_ready;
   logic [OP_W-1:0]   req_op;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;

   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] operand_b;
   logic [DATA_W-1:0] alu_result;
   logic              zero_flag;
   logic              carry_flag;
   logic              overflow_flag;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_wb_en;
   logic              rsp_err;

   logic              status_z;
   logic              status_c;
   logic              status_v;

   modport master (
      input  req_valid, req_op, req_a, req_b,
      input  alu_result, zero_flag, carry_flag, overflow_flag,
      input  rsp_ready,
      output req_ready,
      output alu_op, operand_a, operand_b,
      output rsp_valid, rsp_result, rsp_wb_en, rsp_err,
      output status_z, status_c, status_v
   );

   modport slave (
      output req_valid, req_op, req_a, req_b,
      output alu_result, zero_flag, carry_flag, overflow_flag,
      output rsp_ready,
      input  req_ready,
      input  alu_op, operand_a, operand_b,
      input  rsp_valid, rsp_result, rsp_wb_en, rsp_err,
      input  status_z, status_c, status_v
   );
endinterface

// File: rtl/alu_sequencer.sv
// Drives the combinational alu with registered operands, captures result/flags, returns a response.
// Optional SHIFT_MULTI_EN: SHL/SHR iterate req_b[2:0] times by feeding alu_result back.
module alu_sequencer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned OP_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   alu_sequencer_if.master   bus
);

   localparam logic [OP_W-1:0] OP_SHL = OP_W'(6);
   localparam logic [OP_W-1:0] OP_SHR = OP_W'(7);
   localparam logic [OP_W-1:0] OP_CMP = OP_W'(8);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e            state_q;
   logic              req_ready_q;
   logic [OP_W-1:0]   alu_op_q;
   logic [DATA_W-1:0] operand_a_q;
   logic [DATA_W-1:0] operand_b_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_result_q;
   logic              rsp_wb_en_q;
   logic              rsp_err_q;
   logic              status_z_q;
   logic              status_c_q;
   logic              status_v_q;

`ifdef SHIFT_MULTI_EN
   logic [2:0] shift_cnt_q;
   logic [2:0] shift_cnt_d;
   logic       req_is_shift;

   // Non-shift ops and shifts both leave EXEC when the counter reaches 1.
   always_comb begin
      req_is_shift = (bus.req_op == OP_SHL) || (bus.req_op == OP_SHR);
      shift_cnt_d  = req_is_shift ? bus.req_b[2:0] : 3'd1;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b0;
         alu_op_q     <= '0;
         operand_a_q  <= '0;
         operand_b_q  <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_wb_en_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         status_z_q   <= 1'b0;
         status_c_q   <= 1'b0;
         status_v_q   <= 1'b0;
`ifdef SHIFT_MULTI_EN
         shift_cnt_q  <= 3'd0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               // req_ready comes up on the first edge after reset release
               if (!req_ready_q) begin
                  req_ready_q <= 1'b1;
               end else if (bus.req_valid) begin
                  req_ready_q <= 1'b0;
                  alu_op_q    <= bus.req_op;
                  operand_a_q <= bus.req_a;
                  operand_b_q <= bus.req_b;
`ifdef SHIFT_MULTI_EN
                  shift_cnt_q <= shift_cnt_d;
                  if (req_is_shift && (shift_cnt_d == 3'd0)) begin
                     // zero-count shift bypasses the alu entirely
                     rsp_valid_q  <= 1'b1;
                     rsp_result_q <= bus.req_a;
                     rsp_wb_en_q  <= 1'b1;
                     rsp_err_q    <= 1'b0;
                     status_z_q   <= (bus.req_a == '0);
                     status_c_q   <= 1'b0;
                     status_v_q   <= 1'b0;
                     state_q      <= S_RESP;
                  end else begin
                     state_q <= S_EXEC;
                  end
`else
                  state_q <= S_EXEC;
`endif
               end
            end

            S_EXEC: begin
`ifdef SHIFT_MULTI_EN
               if (shift_cnt_q > 3'd1) begin
                  operand_a_q <= bus.alu_result;
                  shift_cnt_q <= shift_cnt_q - 3'd1;
               end else
`endif
               begin
                  rsp_valid_q  <= 1'b1;
                  rsp_result_q <= bus.alu_result;
                  state_q      <= S_RESP;
                  if (alu_op_q <= OP_CMP) begin
                     rsp_err_q   <= 1'b0;
                     rsp_wb_en_q <= (alu_op_q != OP_CMP);
                     status_z_q  <= bus.zero_flag;
                     status_c_q  <= bus.carry_flag;
                     status_v_q  <= bus.overflow_flag;
                  end else begin
                     // illegal opcode: report, never write back, keep status
                     rsp_err_q   <= 1'b1;
                     rsp_wb_en_q <= 1'b0;
                  end
               end
            end

            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end

            default: begin
               state_q     <= S_IDLE;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.operand_a  = operand_a_q;
   assign bus.operand_b  = operand_b_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_wb_en  = rsp_wb_en_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.status_z   = status_z_q;
   assign bus.status_c   = status_c_q;
   assign bus.status_v   = status_v_q;

endmodule
